writeback_reg_sink: RTL and testbench



---
 rtl/writeback_reg_sink_pkg.sv | 26 ++
 rtl/writeback_reg_sink.sv | 96 +++++++++
 tb/tb_writeback_reg_sink.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/writeback_reg_sink_pkg.sv
// roce_wb_pkg: channel indices, register addresses and priority helper for the writeback sink
package roce_wb_pkg;
  localparam int NUM_WB_CH = 9;
  typedef enum logic [3:0] {
    CH_CQHEAD, CH_SQPSN, CH_LSTRQREQ, CH_INSRRPKTCNT, CH_INAMPKTCNT,
    CH_INNCKPKTSTS, CH_OUTAMPKTCNT, CH_OUTNAKPKTCNT, CH_OUTIOPKTCNT
  } wb_ch_e;
  localparam logic [31:0] CQHEAD_BASE       = 32'h0002_0028;
  localparam logic [31:0] SQPSN_BASE        = 32'h0002_0030;
  localparam logic [31:0] LSTRQREQ_BASE     = 32'h0002_0034;
  localparam logic [31:0] INSRRPKTCNT_ADDR  = 32'h0000_0100;
  localparam logic [31:0] INAMPKTCNT_ADDR   = 32'h0000_0104;
  localparam logic [31:0] INNCKPKTSTS_ADDR  = 32'h0000_0108;
  localparam logic [31:0] OUTAMPKTCNT_ADDR  = 32'h0000_010C;
  localparam logic [31:0] OUTNAKPKTCNT_ADDR = 32'h0000_0110;
  localparam logic [31:0] OUTIOPKTCNT_ADDR  = 32'h0000_0114;
  localparam logic [31:0] CH_ADDR [NUM_WB_CH] = '{
    CQHEAD_BASE, SQPSN_BASE, LSTRQREQ_BASE, INSRRPKTCNT_ADDR, INAMPKTCNT_ADDR,
    INNCKPKTSTS_ADDR, OUTAMPKTCNT_ADDR, OUTNAKPKTCNT_ADDR, OUTIOPKTCNT_ADDR
  };
  function automatic wb_ch_e lowest_set(input logic [NUM_WB_CH-1:0] v);
    lowest_set = CH_CQHEAD;
    for (int i = NUM_WB_CH - 1; i >= 0; i--)
      if (v[i]) lowest_set = wb_ch_e'(4'(i));
  endfunction
endpackage

// File: rtl/writeback_reg_sink.sv
// writeback_reg_sink: captures a batch of writeback channels and serializes them into register writes
module writeback_reg_sink
  import roce_wb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int QP_SHIFT = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wb_valid_i,
  output logic          wb_ready_o,
  input  logic          CQHEADi_wb_valid_i,
  input  logic [39:0]   CQHEADi_wb_i,
  input  logic          SQPSNi_wb_valid_i,
  input  logic [39:0]   SQPSNi_wb_i,
  input  logic          LSTRQREQi_wb_valid_i,
  input  logic [39:0]   LSTRQREQi_wb_i,
  input  logic          INSRRPKTCNT_wb_valid_i,
  input  logic [31:0]   INSRRPKTCNT_wb_i,
  input  logic          INAMPKTCNT_wb_valid_i,
  input  logic [31:0]   INAMPKTCNT_wb_i,
  input  logic          INNCKPKTSTS_wb_valid_i,
  input  logic [31:0]   INNCKPKTSTS_wb_i,
  input  logic          OUTAMPKTCNT_wb_valid_i,
  input  logic [31:0]   OUTAMPKTCNT_wb_i,
  input  logic          OUTNAKPKTCNT_wb_valid_i,
  input  logic [15:0]   OUTNAKPKTCNT_wb_i,
  input  logic          OUTIOPKTCNT_wb_valid_i,
  input  logic [31:0]   OUTIOPKTCNT_wb_i,
  output logic          wr_valid_o,
  input  logic          wr_ready_i,
  output logic [AW-1:0] wr_addr_o,
  output logic [31:0]   wr_data_o
);
  typedef enum logic [1:0] {S_RST, S_IDLE, S_DRAIN} state_e;
  state_e               state_q, state_d;
  logic [NUM_WB_CH-1:0] pend_q, pend_d, vld;
  logic [39:0]          dat_q [NUM_WB_CH];
  logic [39:0]          dat_d [NUM_WB_CH];
  logic [39:0]          din   [NUM_WB_CH];
  wb_ch_e               sel;
  always_comb begin
    vld = {OUTIOPKTCNT_wb_valid_i, OUTNAKPKTCNT_wb_valid_i, OUTAMPKTCNT_wb_valid_i,
           INNCKPKTSTS_wb_valid_i, INAMPKTCNT_wb_valid_i, INSRRPKTCNT_wb_valid_i,
           LSTRQREQi_wb_valid_i, SQPSNi_wb_valid_i, CQHEADi_wb_valid_i};
    din[0] = CQHEADi_wb_i;
    din[1] = SQPSNi_wb_i;
    din[2] = LSTRQREQi_wb_i;
    din[3] = {8'h0, INSRRPKTCNT_wb_i};
    din[4] = {8'h0, INAMPKTCNT_wb_i};
    din[5] = {8'h0, INNCKPKTSTS_wb_i};
    din[6] = {8'h0, OUTAMPKTCNT_wb_i};
    din[7] = {24'h0, OUTNAKPKTCNT_wb_i};
    din[8] = {8'h0, OUTIOPKTCNT_wb_i};
  end
  assign sel        = lowest_set(pend_q);
  assign wb_ready_o = state_q == S_IDLE;
  assign wr_valid_o = state_q == S_DRAIN;
  // Per-QP channels carry their QPN in [39:32]; global channels hold zeros there.
  assign wr_addr_o  = !wr_valid_o ? '0 :
                      sel <= CH_LSTRQREQ ? AW'(CH_ADDR[sel]) + (AW'(dat_q[sel][39:32]) << QP_SHIFT) :
                      AW'(CH_ADDR[sel]);
  assign wr_data_o  = wr_valid_o ? dat_q[sel][31:0] : '0;
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    dat_d   = dat_q;
    case (state_q)
      S_RST: state_d = S_IDLE;
      S_IDLE:
        if (wb_valid_i && |vld) begin
          pend_d = vld;
          for (int i = 0; i < NUM_WB_CH; i++)
            if (vld[i]) dat_d[i] = din[i];
          state_d = S_DRAIN;
        end
      S_DRAIN:
        if (wr_ready_i) begin
          pend_d[sel] = 1'b0;
          state_d     = pend_d == '0 ? S_IDLE : S_DRAIN;
        end
      default: state_d = S_RST;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_RST;
      pend_q  <= '0;
      dat_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      dat_q   <= dat_d;
    end
  end
endmodule

// File: tb/tb_writeback_reg_sink.sv
// tb_writeback_reg_sink: random and directed stimulus against a queue-based model of the write stream
module tb_writeback_reg_sink;
  logic        clk, rst, wb_valid, wb_ready_o, wr_valid_o, wr_ready;
  logic [31:0] wr_addr_o, wr_data_o;
  logic [8:0]  v;
  logic [39:0] d [9];
  logic [63:0] q [$];
  logic        m_rst, m_known;
  int          checks, errors, n_wr;

  writeback_reg_sink dut (
    .clk_i(clk), .rst_i(rst), .wb_valid_i(wb_valid), .wb_ready_o(wb_ready_o),
    .CQHEADi_wb_valid_i(v[0]),      .CQHEADi_wb_i(d[0]),
    .SQPSNi_wb_valid_i(v[1]),       .SQPSNi_wb_i(d[1]),
    .LSTRQREQi_wb_valid_i(v[2]),    .LSTRQREQi_wb_i(d[2]),
    .INSRRPKTCNT_wb_valid_i(v[3]),  .INSRRPKTCNT_wb_i(d[3][31:0]),
    .INAMPKTCNT_wb_valid_i(v[4]),   .INAMPKTCNT_wb_i(d[4][31:0]),
    .INNCKPKTSTS_wb_valid_i(v[5]),  .INNCKPKTSTS_wb_i(d[5][31:0]),
    .OUTAMPKTCNT_wb_valid_i(v[6]),  .OUTAMPKTCNT_wb_i(d[6][31:0]),
    .OUTNAKPKTCNT_wb_valid_i(v[7]), .OUTNAKPKTCNT_wb_i(d[7][15:0]),
    .OUTIOPKTCNT_wb_valid_i(v[8]),  .OUTIOPKTCNT_wb_i(d[8][31:0]),
    .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] expect_write(input int ch, input logic [39:0] dd);
    logic [31:0] a, x;
    case (ch)
      0: a = 32'h0002_0028 + ({24'h0, dd[39:32]} << 8);
      1: a = 32'h0002_0030 + ({24'h0, dd[39:32]} << 8);
      2: a = 32'h0002_0034 + ({24'h0, dd[39:32]} << 8);
      3: a = 32'h100;
      4: a = 32'h104;
      5: a = 32'h108;
      6: a = 32'h10C;
      7: a = 32'h110;
      default: a = 32'h114;
    endcase
    x = ch == 7 ? {16'h0, dd[15:0]} : dd[31:0];
    return {a, x};
  endfunction

  // Model: a batch becomes an ordered list of writes, consumed one per accepted handshake.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_rst   = 1;
      m_known = 1;
    end else if (m_rst) m_rst = 0;
    else if (q.size() == 0) begin
      if (wb_valid && |v)
        for (int ch = 0; ch < 9; ch++)
          if (v[ch]) q.push_back(expect_write(ch, d[ch]));
    end else if (wr_ready) begin
      void'(q.pop_front());
      n_wr++;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      logic        ev;
      logic [63:0] ew;
      ev = !m_rst && q.size() != 0;
      ew = ev ? q[0] : 64'h0;
      chk("wb_ready", {63'h0, wb_ready_o}, {63'h0, !m_rst && q.size() == 0});
      chk("wr_valid", {63'h0, wr_valid_o}, {63'h0, ev});
      chk("wr_addr", {32'h0, wr_addr_o}, {32'h0, ew[63:32]});
      chk("wr_data", {32'h0, wr_data_o}, {32'h0, ew[31:0]});
    end
  end

  task automatic clr();
    v        = '0;
    wb_valid = 0;
  endtask

  initial begin
    int n0;
    checks = 0; errors = 0; n_wr = 0; m_rst = 1; m_known = 0;
    rst = 1; wr_ready = 0; clr();
    for (int i = 0; i < 9; i++) d[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {63'h0, wb_ready_o}, 64'h0);
    chk("rst_valid", {63'h0, wr_valid_o}, 64'h0);
    chk("rst_addr", {32'h0, wr_addr_o}, 64'h0);
    rst = 0;
    @(negedge clk);
    chk("rel_ready", {63'h0, wb_ready_o}, 64'h1);
    chk("rel_valid", {63'h0, wr_valid_o}, 64'h0);
    // single global channel
    v[4] = 1; d[4] = 40'hDE_ADBE_EF; wb_valid = 1; wr_ready = 1;
    @(negedge clk); clr();
    chk("inam_valid", {63'h0, wr_valid_o}, 64'h1);
    chk("inam_ready", {63'h0, wb_ready_o}, 64'h0);
    chk("inam_addr", {32'h0, wr_addr_o}, 64'h104);
    chk("inam_data", {32'h0, wr_data_o}, 64'hDEADBEEF);
    @(negedge clk);
    chk("inam_idle", {63'h0, wb_ready_o}, 64'h1);
    // per-QP plus 16-bit counter in one batch
    v[0] = 1; d[0] = 40'h05_0000_0012; v[7] = 1; d[7] = 40'h0ABCD; wb_valid = 1;
    @(negedge clk); clr();
    chk("cq_addr", {32'h0, wr_addr_o}, 64'h20528);
    chk("cq_data", {32'h0, wr_data_o}, 64'h12);
    @(negedge clk);
    chk("nak_addr", {32'h0, wr_addr_o}, 64'h110);
    chk("nak_data", {32'h0, wr_data_o}, 64'hABCD);
    @(negedge clk);
    chk("pair_idle", {63'h0, wb_ready_o}, 64'h1);
    // all nine with a stalling write port
    v = '1; wb_valid = 1;
    for (int i = 0; i < 9; i++) d[i] = {8'($urandom), 32'($urandom)};
    n0 = n_wr;
    @(negedge clk); clr();
    for (int c = 0; c < 40; c++) begin
      wr_ready = c[0];
      @(negedge clk);
      if (wb_ready_o) break;
    end
    chk("all9_done", {63'h0, wb_ready_o}, 64'h1);
    chk("all9_count", 64'(n_wr - n0), 64'd9);
    // new channel asserted mid-drain waits for idle
    wr_ready = 1;
    v[0] = 1; v[3] = 1; v[8] = 1; wb_valid = 1;
    @(negedge clk); clr();
    v[1] = 1; d[1] = 40'h07_1234_5678; wb_valid = 1;
    @(negedge clk);
    chk("mid_ready", {63'h0, wb_ready_o}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_idle", {63'h0, wb_ready_o}, 64'h1);
    @(negedge clk); clr();
    chk("sq_addr", {32'h0, wr_addr_o}, 64'h20730);
    chk("sq_data", {32'h0, wr_data_o}, 64'h12345678);
    @(negedge clk);
    chk("sq_idle", {63'h0, wb_ready_o}, 64'h1);
    // reset after three accepted writes
    v = '1; wb_valid = 1;
    @(negedge clk); clr();
    repeat (3) @(negedge clk);
    wr_ready = 0; rst = 1;
    @(negedge clk);
    chk("mrst_valid", {63'h0, wr_valid_o}, 64'h0);
    chk("mrst_ready", {63'h0, wb_ready_o}, 64'h0);
    rst = 0; wr_ready = 1;
    @(negedge clk);
    chk("mrst_rel", {63'h0, wb_ready_o}, 64'h1);
    repeat (4) @(negedge clk);
    chk("mrst_quiet", {63'h0, wr_valid_o}, 64'h0);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      v = $urandom_range(0, 3) == 0 ? 9'($urandom) : 9'h0;
      for (int ch = 0; ch < 9; ch++) d[ch] = {8'($urandom), 32'($urandom)};
      wb_valid = $urandom_range(0, 9) == 0 ? !(|v) : |v;
      wr_ready = $urandom_range(0, 2) != 0;
      rst      = $urandom_range(0, 99) == 0;
      @(negedge clk);
    end
    rst = 0; wr_ready = 1; clr();
    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
